// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: shared state encoding, widths and helpers for the PLL reset sequencer
package pll_reset_pkg;
   typedef enum logic [1:0] {HOLD, WAIT_LOCK, STABILIZE, RUN} state_e;
   localparam int LOSS_W = 8;
   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop synchroniser for an asynchronous level, flops reset to 0
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) sync_q <= '0;
      else sync_q <= {sync_q[STAGES-2:0], d_i};
   assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: holds system reset until the PLL lock has been stable long enough, tracks lock losses
module pll_reset_seq
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int HOLD_CYCLES   = 16,
   parameter int STABLE_CYCLES = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              locked_i,
   input  logic              clear_i,
   output logic              sys_reset_o,
   output logic              ready_o,
   output logic              lost_o,
   output logic [LOSS_W-1:0] loss_count_o
);
   localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STABLE_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   logic              locked_s;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LOSS_W-1:0] loss_q, loss_d;
   logic              sys_reset_q, ready_q, lost_q, lost_d;
   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d_i     (locked_i),
      .q_o     (locked_s)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         HOLD:      state_d = (cnt_q == HOLD_LAST) ? WAIT_LOCK : HOLD;
         WAIT_LOCK: state_d = locked_s ? STABILIZE : WAIT_LOCK;
         STABILIZE: state_d = !locked_s ? WAIT_LOCK : (cnt_q == STABLE_LAST) ? RUN : STABILIZE;
         RUN:       state_d = locked_s ? RUN : HOLD;
      endcase
      // the counter only runs in the two timed states and restarts on every transition
      cnt_d  = (state_d != state_q || state_q == WAIT_LOCK || state_q == RUN) ? '0 : cnt_q + CNT_W'(1);
      lost_d = (state_q == RUN) && !locked_s;
      loss_d = clear_i ? '0 : (lost_d && loss_q != '1) ? loss_q + LOSS_W'(1) : loss_q;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         loss_q      <= '0;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         loss_q      <= loss_d;
         sys_reset_q <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
         lost_q      <= lost_d;
      end
   assign sys_reset_o  = sys_reset_q;
   assign ready_o      = ready_q;
   assign lost_o       = lost_q;
   assign loss_count_o = loss_q;
endmodule
